instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Front end of the core; the producer side of the decoder's `instr` input.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel, one request outstanding at a time.
- Buffers returned words with their PC in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Accepts redirects (branch/JAL/JALR targets) that flush buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  word-aligned fetch address (current PC).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  read data valid; always accepted, no backpressure.
- imem_rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  buffer head valid.
- instr  out  32  buffer head instruction; 32'h0 when empty.
- instr_pc  out  32  PC of buffer head; 32'h0 when empty.
- instr_ready  in  1  downstream consumes head.
- redirect_valid  in  1  load new PC, flush.
- redirect_pc  in  32  redirect target.
- misaligned_err  out  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC; state = FETCH; FIFO empty.
  - Outputs: instr_valid = 0, instr = 0, instr_pc = 0, misaligned_err = 0.
  - imem_req_valid is not a register; it follows the FETCH rule below, so it is 1 from the first cycle after reset deasserts.
  - Reset mid-transaction drops any in-flight response; a response arriving after reset is ignored because the state is FETCH.
- States: FETCH, WAIT, DROP.
- FETCH:
  - imem_req_valid = 1 iff fifo_count < FIFO_DEPTH.
  - imem_req_addr = pc.
  - On valid & ready: req_pc <= pc; pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); go to WAIT.
- WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid: push {req_pc, imem_rsp_data}; go to FETCH.
  - Space is guaranteed because a request is issued only when count < DEPTH and no other push can occur.
- DROP:
  - imem_req_valid = 0.
  - On imem_rsp_valid: discard data; go to FETCH.
- Latency:
  - Response in cycle N -> instr_valid = 1 in cycle N+1.
  - The next request may issue in cycle N+1.
  - Minimum 2 cycles per instruction at zero memory latency.
- FIFO:
  - instr_valid = (count != 0).
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (redirect_valid = 1), takes priority over every other event in the same cycle:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO flushed (count = 0); any same-cycle pop or push is cancelled.
  - From FETCH with a request accepted the same cycle: the request is in flight; go to DROP; pc is still the redirect target.
  - From FETCH with no acceptance: stay in FETCH.
  - From WAIT: go to DROP, unless imem_rsp_valid is high the same cycle; then discard it and go to FETCH.
  - From DROP: stay in DROP (the response is still owed), unless imem_rsp_valid is high the same cycle; then go to FETCH.
  - imem_req_valid is still driven the same cycle from the old pc; the redirect applies from the next cycle.
- misaligned_err is registered: 1 for exactly one cycle after a redirect with redirect_pc[1:0] != 0; otherwise 0.
- Invariants:
  - At most one outstanding request.
  - FIFO never overflows.
  - instr_pc is always the address the word was fetched from.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH, WAIT, DROP}.
  - localparam PC_STEP = 4.
  - localparam NOP = 32'h0000_0013, for downstream bubble insertion.
- One sub-module, instr_fifo:
  - Parameterised width and depth.
  - push/pop/flush; head data and count outputs.
  - Async active-high reset.
- instr_fetch holds the PC, FSM and redirect logic.

Test Plan:
- Straight-line fetch:
  - Stimulus: reset released, memory ready = 1, 1-cycle response, instr_ready = 1, memory returns 32'h00000033, 32'h00000013, 32'h00000063.
  - Response: req addresses 0x0, 0x4, 0x8; instr/instr_pc pairs (33, 0x0), (13, 0x4), (63, 0x8), each valid one cycle after its rsp.
- Backpressure:
  - Stimulus: instr_ready = 0.
  - Response: exactly 2 words buffered (PCs 0x0, 0x4); imem_req_valid = 0 while full; releasing ready drains both in order, then fetching resumes at 0x8.
- Redirect while WAIT:
  - Stimulus: redirect_pc = 0x100 while a request to 0x8 is outstanding.
  - Response: FIFO empties next cycle; the 0x8 response is dropped; next request addr = 0x100; first delivered instr_pc = 0x100.
- Redirect coincident with response or pop:
  - Stimulus: redirect in the same cycle as imem_rsp_valid and instr_ready.
  - Response: nothing pushed or popped; state FETCH; next req addr = target.
- Misaligned redirect:
  - Stimulus: redirect_pc = 0x0000_0206.
  - Response: misaligned_err = 1 for one cycle; next req addr = 0x204.
- PC wrap and async reset:
  - Stimulus: redirect to 0xFFFF_FFFC, fetch two words; then assert reset mid-WAIT.
  - Response: addresses 0xFFFF_FFFC then 0x0; on reset, outputs clear immediately; a late rsp is ignored; first req after release = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Canonical addi x0,x0,0; the decoder side uses it when inserting bubbles.
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding fetched words with their PCs.
// Flush wins over push and pop issued in the same cycle.
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~flush & (count != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push & ~flush & ((count != FULL_CNT) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: PC, single-outstanding imem request FSM, redirect handling,
// and an instruction buffer feeding the decoder.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   req_pc;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          flush;
    logic [63:0]   fifo_head;
    logic [CW-1:0] fifo_count;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; imem responses have no ready and are taken whenever valid.
    assign imem_req_valid = (state == FETCH) && (fifo_count < DEPTH_CNT);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? fifo_head[31:0]  : 32'h0;
    assign instr_pc    = instr_valid ? fifo_head[63:32] : 32'h0;

    assign flush = redirect_valid;
    assign pop   = instr_valid & instr_ready & ~redirect_valid;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;

        case (state)
            FETCH: begin
                if (req_fire) begin
                    state_next = WAIT;
                    pc_next    = pc + PC_STEP;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push       = 1'b1;
                    state_next = FETCH;
                end
            end
            DROP: begin
                if (imem_rsp_valid) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // A redirect overrides everything; a request still owed a response
        // parks the FSM in DROP so the stale word is swallowed.
        if (redirect_valid) begin
            push    = 1'b0;
            pc_next = {redirect_pc[31:2], 2'b00};
            if (state == FETCH) state_next = req_fire ? DROP : FETCH;
            else                state_next = imem_rsp_valid ? FETCH : DROP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            req_pc         <= RESET_PC;
            misaligned_err <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            if (req_fire) req_pc <= pc;
            misaligned_err <= redirect_valid & (redirect_pc[1:0] != 2'b00);
        end
    end

    instr_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({req_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural imem, expected-word queue, directed and random phases.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned_err;

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned_err (misaligned_err)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        exp_mis;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          drop_pending;
    bit          stale_rsp;
    int          rsp_delay = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0033;
            32'h0000_0004: return 32'h0000_0013;
            32'h0000_0008: return 32'h0000_0063;
            default:       return {a[31:2], 2'b11} ^ 32'h5A00_0000;
        endcase
    endfunction

    // One clock cycle, entered and left at a falling edge; the caller has set
    // the request/consumer/redirect inputs, the memory model sets the response.
    task automatic tick();
        logic        fire;
        logic        rsp_real;
        logic [31:0] fire_addr;
        rsp_real = 1'b0;
        if (stale_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            stale_rsp      = 1'b0;
        end else if (mem_busy && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            rsp_real       = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        check("misaligned_err", misaligned_err, exp_mis);
        check("instr_valid", instr_valid, exp_q.size() != 0);
        check("imem_req_valid", imem_req_valid, !mem_busy && exp_q.size() < 2);
        if (exp_q.size() != 0) begin
            check("instr", instr, exp_q[0][31:0]);
            check("instr_pc", instr_pc, exp_q[0][63:32]);
        end else begin
            check("instr_empty", instr, 64'h0);
            check("instr_pc_empty", instr_pc, 64'h0);
        end

        fire      = imem_req_valid && imem_req_ready;
        fire_addr = imem_req_addr;
        if (fire) begin
            check("req_addr", fire_addr, exp_pc);
            check("one_outstanding", mem_busy, 64'h0);
            exp_pc = exp_pc + 32'd4;
        end
        if (instr_valid && instr_ready && !redirect_valid && exp_q.size() != 0)
            void'(exp_q.pop_front());
        if (rsp_real) begin
            if (!drop_pending && !redirect_valid)
                exp_q.push_back({mem_addr, mem_word(mem_addr)});
            drop_pending = 1'b0;
            mem_busy     = 1'b0;
        end
        if (redirect_valid) begin
            exp_q.delete();
            if (fire || mem_busy) drop_pending = 1'b1;
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (fire) begin
            mem_busy = 1'b1;
            mem_addr = fire_addr;
            mem_cnt  = rsp_delay - 1;
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset between edges and checks that outputs clear at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_instr_valid", instr_valid, 64'h0);
        check("rst_instr", instr, 64'h0);
        check("rst_instr_pc", instr_pc, 64'h0);
        check("rst_misaligned", misaligned_err, 64'h0);
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_pc       = 32'h0000_0000;
        exp_mis      = 1'b0;
        mem_busy     = 1'b0;
        mem_cnt      = 0;
        mem_addr     = 32'hFFFF_FFFF;
        drop_pending = 1'b0;
        stale_rsp    = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);

        // Straight-line fetch of 0x0, 0x4, 0x8 and onward
        do_reset();
        run(8);

        // Backpressure: buffer fills at two words, then drains in order
        do_reset();
        instr_ready = 1'b0;
        run(10);
        instr_ready = 1'b1;
        run(8);

        // Redirect while the 0x8 request is outstanding
        do_reset();
        rsp_delay = 3;
        for (int i = 0; i < 40; i++) begin
            if (mem_busy && mem_addr == 32'h8) break;
            tick();
        end
        check("reach_wait_0x8", mem_busy && mem_addr == 32'h8, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        run(12);

        // Redirect coincident with a response and a pop
        do_reset();
        rsp_delay   = 1;
        instr_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_busy && mem_cnt == 0 && exp_q.size() != 0) break;
            tick();
        end
        check("reach_rsp_and_head", mem_busy && mem_cnt == 0 && exp_q.size() != 0, 64'h1);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        run(8);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0206;
        tick();
        redirect_valid = 1'b0;
        run(8);

        // PC wrap, then asynchronous reset while a request is outstanding
        rsp_delay      = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_busy && mem_addr == 32'h0) break;
            tick();
        end
        check("reach_wrap_0x0", mem_busy && mem_addr == 32'h0, 64'h1);
        do_reset();
        rsp_delay = 1;
        stale_rsp = 1'b1;
        run(10);

        // Random traffic with occasional redirects
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            rsp_delay      = $urandom_range(1, 3);
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
